// File: rtl/output_accum_mem.sv
// Multi-port output tile buffer for the Winograd PE array: per-channel read, overwrite and
// saturating lane accumulate, plus command-driven scan-in, scan-out and row-by-row clear.
module output_accum_mem #(
  parameter  int NUM_PORTS = 2,
  parameter  int DATA_W    = 512,
  parameter  int DEPTH     = 128,
  parameter  int LANE_W    = 16,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        cmd_valid,
  input  logic [1:0]                  cmd_mode,
  output logic                        busy,
  input  logic [NUM_PORTS-1:0]        pkt_valid_in,
  input  logic [NUM_PORTS-1:0]        pkt_we_in,
  input  logic [NUM_PORTS-1:0]        pkt_acc_in,
  input  logic [NUM_PORTS*AW-1:0]     addr_in,
  input  logic [NUM_PORTS*DATA_W-1:0] data_in,
  output logic [NUM_PORTS-1:0]        pkt_valid_out,
  output logic [NUM_PORTS*AW-1:0]     addr_out,
  output logic [NUM_PORTS*DATA_W-1:0] data_out,
  output logic                        collision_err,
  input  logic                        scan_in_valid,
  input  logic [DATA_W-1:0]           scan_in_data,
  output logic                        scan_out_valid,
  input  logic                        scan_out_ready,
  output logic [DATA_W-1:0]           scan_out_data
);

  localparam int            LANES    = DATA_W / LANE_W;
  localparam logic [AW-1:0] LAST_ROW = AW'(DEPTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_SCAN_IN,
    ST_SCAN_OUT,
    ST_CLEAR
  } state_t;

  typedef enum logic [1:0] {
    CMD_RUN      = 2'd0,
    CMD_SCAN_IN  = 2'd1,
    CMD_SCAN_OUT = 2'd2,
    CMD_CLEAR    = 2'd3
  } cmd_t;

  state_t               state;
  state_t               state_next;
  logic [AW-1:0]        cnt;
  logic [AW-1:0]        cnt_inc;
  logic                 cnt_last;
  logic                 cmd_accept;

  logic [DATA_W-1:0]    mem [DEPTH];

  logic [AW-1:0]        req_addr [NUM_PORTS];
  logic [DATA_W-1:0]    req_data [NUM_PORTS];
  logic [DATA_W-1:0]    old_row  [NUM_PORTS];
  logic [DATA_W-1:0]    new_row  [NUM_PORTS];
  logic [NUM_PORTS-1:0] pkt_take;
  logic [NUM_PORTS-1:0] wr_req;
  logic [NUM_PORTS-1:0] wr_drop;
  logic [NUM_PORTS-1:0] wr_en;

  // Per-lane signed add; overflow is detected from the extra sign bit and clamped.
  function automatic logic [DATA_W-1:0] sat_add(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] r;
    logic [LANE_W:0]   s;
    r = '0;
    for (int i = 0; i < LANES; i++) begin
      s = {a[i*LANE_W+LANE_W-1], a[i*LANE_W +: LANE_W]} +
          {b[i*LANE_W+LANE_W-1], b[i*LANE_W +: LANE_W]};
      if (s[LANE_W] != s[LANE_W-1])
        r[i*LANE_W +: LANE_W] = s[LANE_W] ? {1'b1, {(LANE_W-1){1'b0}}}
                                          : {1'b0, {(LANE_W-1){1'b1}}};
      else
        r[i*LANE_W +: LANE_W] = s[LANE_W-1:0];
    end
    return r;
  endfunction

  assign busy       = (state == ST_SCAN_IN) || (state == ST_SCAN_OUT) || (state == ST_CLEAR);
  assign cmd_accept = cmd_valid && !busy;
  assign cnt_last   = (cnt == LAST_ROW);
  assign cnt_inc    = cnt_last ? '0 : cnt + AW'(1);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_RUN: begin
        if (cmd_valid) begin
          case (cmd_t'(cmd_mode))
            CMD_RUN:      state_next = ST_RUN;
            CMD_SCAN_IN:  state_next = ST_SCAN_IN;
            CMD_SCAN_OUT: state_next = ST_SCAN_OUT;
            default:      state_next = ST_CLEAR;
          endcase
        end
      end
      ST_SCAN_IN:  if (scan_in_valid && cnt_last) state_next = ST_IDLE;
      ST_SCAN_OUT: if (scan_out_valid && scan_out_ready && cnt_last) state_next = ST_IDLE;
      ST_CLEAR:    if (cnt_last) state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  // Channel decode; on a same-address write clash only the lowest-index writer survives.
  always_comb begin
    pkt_take = '0;
    wr_req   = '0;
    wr_drop  = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      req_addr[p] = addr_in[p*AW +: AW];
      req_data[p] = data_in[p*DATA_W +: DATA_W];
      old_row[p]  = mem[req_addr[p]];
      new_row[p]  = pkt_acc_in[p] ? sat_add(old_row[p], req_data[p]) : req_data[p];
      pkt_take[p] = (state == ST_RUN) && pkt_valid_in[p];
      wr_req[p]   = pkt_take[p] && pkt_we_in[p];
    end
    for (int p = 1; p < NUM_PORTS; p++) begin
      for (int q = 0; q < p; q++) begin
        if (wr_req[p] && wr_req[q] && (req_addr[q] == req_addr[p])) wr_drop[p] = 1'b1;
      end
    end
  end

  assign wr_en = wr_req & ~wr_drop;

  // NOTE: the row storage is deliberately left unreset; CLEAR zeroes it when needed.
  always_ff @(posedge clk) begin
    case (state)
      ST_RUN: begin
        for (int p = 0; p < NUM_PORTS; p++) begin
          if (wr_en[p]) mem[req_addr[p]] <= new_row[p];
        end
      end
      ST_SCAN_IN: if (scan_in_valid) mem[cnt] <= scan_in_data;
      ST_CLEAR:   mem[cnt] <= '0;
      default: ;
    endcase
  end

  // Scan counter and scan-out holding register; the word stays put until it is taken.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt            <= '0;
      scan_out_valid <= 1'b0;
      scan_out_data  <= '0;
    end else if (cmd_accept) begin
      cnt            <= '0;
      scan_out_valid <= 1'b0;
    end else begin
      case (state)
        ST_SCAN_IN: if (scan_in_valid) cnt <= cnt_inc;
        ST_CLEAR:   cnt <= cnt_inc;
        ST_SCAN_OUT: begin
          if (!scan_out_valid) begin
            scan_out_valid <= 1'b1;
            scan_out_data  <= mem[cnt];
          end else if (scan_out_ready) begin
            cnt            <= cnt_inc;
            scan_out_valid <= !cnt_last;
            scan_out_data  <= mem[cnt_inc];
          end
        end
        default: ;
      endcase
    end
  end

  // Responses carry the row as it was before this cycle's update.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pkt_valid_out <= '0;
      addr_out      <= '0;
      data_out      <= '0;
      collision_err <= 1'b0;
    end else begin
      pkt_valid_out <= pkt_take;
      collision_err <= |wr_drop;
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (pkt_take[p]) begin
          addr_out[p*AW +: AW]         <= req_addr[p];
          data_out[p*DATA_W +: DATA_W] <= old_row[p];
        end
      end
    end
  end

endmodule

// File: tb/tb_output_accum_mem.sv
// Self-checking bench for output_accum_mem: directed vector table, randomized RUN traffic
// against a row-array reference model, and scan/clear/reset sequences.
module tb_output_accum_mem;

  localparam int NP     = 2;
  localparam int DATA_W = 512;
  localparam int DEPTH  = 128;
  localparam int LANE_W = 16;
  localparam int AW     = 7;
  localparam int LANES  = DATA_W / LANE_W;
  localparam int NV     = 22;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 cmd_valid;
  logic [1:0]           cmd_mode;
  logic                 busy;
  logic [NP-1:0]        pkt_valid_in;
  logic [NP-1:0]        pkt_we_in;
  logic [NP-1:0]        pkt_acc_in;
  logic [NP*AW-1:0]     addr_in;
  logic [NP*DATA_W-1:0] data_in;
  logic [NP-1:0]        pkt_valid_out;
  logic [NP*AW-1:0]     addr_out;
  logic [NP*DATA_W-1:0] data_out;
  logic                 collision_err;
  logic                 scan_in_valid;
  logic [DATA_W-1:0]    scan_in_data;
  logic                 scan_out_valid;
  logic                 scan_out_ready;
  logic [DATA_W-1:0]    scan_out_data;

  output_accum_mem #(
    .NUM_PORTS(NP), .DATA_W(DATA_W), .DEPTH(DEPTH), .LANE_W(LANE_W)
  ) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_mode(cmd_mode), .busy(busy),
    .pkt_valid_in(pkt_valid_in), .pkt_we_in(pkt_we_in), .pkt_acc_in(pkt_acc_in),
    .addr_in(addr_in), .data_in(data_in), .pkt_valid_out(pkt_valid_out),
    .addr_out(addr_out), .data_out(data_out), .collision_err(collision_err),
    .scan_in_valid(scan_in_valid), .scan_in_data(scan_in_data),
    .scan_out_valid(scan_out_valid), .scan_out_ready(scan_out_ready),
    .scan_out_data(scan_out_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]    v, we, acc;
    logic [AW-1:0] a0, a1;
    logic [15:0]   l0, l1;
    logic [15:0]   e0, e1;
    logic          col;
  } vec_t;

  int                checks   = 0;
  int                failures = 0;
  logic [DATA_W-1:0] model [DEPTH];
  logic [DATA_W-1:0] exp_d0, exp_d1;
  logic              exp_col;
  vec_t              tbl [NV];

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DATA_W-1:0] rep(input logic [15:0] l);
    return {LANES{l}};
  endfunction

  function automatic vec_t mk(input logic [1:0] v, we, acc, input int a0, a1,
                              input logic [15:0] l0, l1, e0, e1, input logic col);
    vec_t r;
    r.v = v; r.we = we; r.acc = acc; r.a0 = AW'(a0); r.a1 = AW'(a1);
    r.l0 = l0; r.l1 = l1; r.e0 = e0; r.e1 = e1; r.col = col;
    return r;
  endfunction

  // Reference accumulate: integer sum per lane, clamped to the signed 16-bit range.
  function automatic logic [DATA_W-1:0] model_acc(input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] r;
    int s;
    for (int i = 0; i < LANES; i++) begin
      s = int'($signed(a[i*16 +: 16])) + int'($signed(b[i*16 +: 16]));
      if (s > 32767) s = 32767;
      else if (s < -32768) s = -32768;
      r[i*16 +: 16] = 16'(s);
    end
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] rand_lanes();
    logic [DATA_W-1:0] r;
    for (int i = 0; i < LANES; i++) begin
      case ($urandom_range(0, 3))
        0:       r[i*16 +: 16] = 16'h7F00 | 16'($urandom_range(0, 255));
        1:       r[i*16 +: 16] = 16'h8000 | 16'($urandom_range(0, 255));
        2:       r[i*16 +: 16] = 16'($urandom_range(0, 15));
        default: r[i*16 +: 16] = 16'($urandom);
      endcase
    end
    return r;
  endfunction

  task automatic send_cmd(input logic [1:0] m);
    cmd_valid = 1'b1;
    cmd_mode  = m;
    step();
    cmd_valid = 1'b0;
  endtask

  // Drives one packet cycle; expectations come from the model before it is updated.
  task automatic pkt_cycle(input logic [1:0] v, we, acc, input logic [AW-1:0] a0, a1,
                           input logic [DATA_W-1:0] d0, d1);
    logic [AW-1:0]     a [NP];
    logic [DATA_W-1:0] d [NP];
    bit                written [DEPTH];
    a[0] = a0; a[1] = a1; d[0] = d0; d[1] = d1;
    foreach (written[i]) written[i] = 1'b0;
    pkt_valid_in = v; pkt_we_in = we; pkt_acc_in = acc;
    addr_in = {a1, a0}; data_in = {d1, d0};
    exp_d0 = model[a0];
    exp_d1 = model[a1];
    exp_col = 1'b0;
    for (int p = 0; p < NP; p++) begin
      if (v[p] && we[p]) begin
        if (written[a[p]]) exp_col = 1'b1;
        else begin
          written[a[p]] = 1'b1;
          model[a[p]] = acc[p] ? model_acc(model[a[p]], d[p]) : d[p];
        end
      end
    end
    step();
    pkt_valid_in = '0;
  endtask

  task automatic check_resp(input string tag, input logic [1:0] v, input logic [AW-1:0] a0, a1,
                            input logic [DATA_W-1:0] e0, e1, input logic col);
    check({tag, "_valid"}, DATA_W'(pkt_valid_out), DATA_W'(v));
    if (v[0]) begin
      check({tag, "_addr0"}, DATA_W'(addr_out[AW-1:0]), DATA_W'(a0));
      check({tag, "_data0"}, data_out[DATA_W-1:0], e0);
    end
    if (v[1]) begin
      check({tag, "_addr1"}, DATA_W'(addr_out[2*AW-1:AW]), DATA_W'(a1));
      check({tag, "_data1"}, data_out[2*DATA_W-1:DATA_W], e1);
    end
    check({tag, "_collision"}, DATA_W'(collision_err), DATA_W'(col));
  endtask

  task automatic do_clear();
    int n = 0;
    send_cmd(2'd3);
    while (busy && n < DEPTH + 50) begin
      step();
      n++;
    end
    check("clear_cycles", DATA_W'(n), DATA_W'(DEPTH));
    foreach (model[i]) model[i] = '0;
  endtask

  // rmode: 0 ready always high, 1 ready toggles 1010.., 2 random ready.
  task automatic scan_out_check(input int rmode);
    int                idx = 0;
    int                cyc = 0;
    logic              r;
    logic              held_v = 1'b0;
    logic [DATA_W-1:0] held = '0;
    send_cmd(2'd2);
    check("scan_out_first_gap", DATA_W'(scan_out_valid), '0);
    while (idx < DEPTH && cyc < 6 * DEPTH) begin
      r = (rmode == 0) ? 1'b1 : (rmode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      scan_out_ready = r;
      if (scan_out_valid) begin
        if (held_v) check("scan_out_stable", scan_out_data, held);
        if (r) begin
          check($sformatf("scan_out_word%0d", idx), scan_out_data, model[idx]);
          idx++;
          held_v = 1'b0;
        end else begin
          held_v = 1'b1;
          held   = scan_out_data;
        end
      end
      step();
      cyc++;
    end
    scan_out_ready = 1'b0;
    check("scan_out_count", DATA_W'(idx), DATA_W'(DEPTH));
    check("scan_out_done_busy", DATA_W'(busy), '0);
    check("scan_out_done_valid", DATA_W'(scan_out_valid), '0);
  endtask

  task automatic scan_in_load();
    int idx = 0;
    int cyc = 0;
    send_cmd(2'd1);
    while (idx < DEPTH && cyc < 6 * DEPTH) begin
      scan_in_valid = ($urandom_range(0, 3) != 0);
      scan_in_data  = rand_lanes();
      cmd_valid     = (cyc == 5);
      cmd_mode      = 2'd3;
      if (scan_in_valid) begin
        model[idx] = scan_in_data;
        idx++;
      end
      step();
      cyc++;
    end
    scan_in_valid = 1'b0;
    cmd_valid     = 1'b0;
    check("scan_in_done_busy", DATA_W'(busy), '0);
  endtask

  initial begin
    reset = 1'b0; cmd_valid = 1'b0; cmd_mode = '0;
    pkt_valid_in = '0; pkt_we_in = '0; pkt_acc_in = '0; addr_in = '0; data_in = '0;
    scan_in_valid = 1'b0; scan_in_data = '0; scan_out_ready = 1'b0;
    foreach (model[i]) model[i] = '0;

    tbl[0]  = mk(2'b01, 2'b01, 2'b00,  5,  0, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    tbl[1]  = mk(2'b10, 2'b00, 2'b00,  0,  5, 16'h0000, 16'h0000, 16'h0000, 16'h1234, 1'b0);
    tbl[2]  = mk(2'b01, 2'b01, 2'b00,  7,  0, 16'h7FF0, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    tbl[3]  = mk(2'b01, 2'b01, 2'b01,  7,  0, 16'h0020, 16'h0000, 16'h7FF0, 16'h0000, 1'b0);
    tbl[4]  = mk(2'b01, 2'b00, 2'b00,  7,  0, 16'h0000, 16'h0000, 16'h7FFF, 16'h0000, 1'b0);
    tbl[5]  = mk(2'b01, 2'b01, 2'b00,  8,  0, 16'h8000, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    tbl[6]  = mk(2'b01, 2'b01, 2'b01,  8,  0, 16'hFFFF, 16'h0000, 16'h8000, 16'h0000, 1'b0);
    tbl[7]  = mk(2'b11, 2'b00, 2'b00,  8,  8, 16'h0000, 16'h0000, 16'h8000, 16'h8000, 1'b0);
    tbl[8]  = mk(2'b11, 2'b11, 2'b00,  9,  9, 16'hAAAA, 16'h5555, 16'h0000, 16'h0000, 1'b1);
    tbl[9]  = mk(2'b11, 2'b00, 2'b00,  9,  9, 16'h0000, 16'h0000, 16'hAAAA, 16'hAAAA, 1'b0);
    tbl[10] = mk(2'b01, 2'b01, 2'b01,  3,  0, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    tbl[11] = mk(2'b01, 2'b01, 2'b01,  3,  0, 16'h0001, 16'h0000, 16'h0001, 16'h0000, 1'b0);
    tbl[12] = mk(2'b01, 2'b01, 2'b01,  3,  0, 16'h0001, 16'h0000, 16'h0002, 16'h0000, 1'b0);
    tbl[13] = mk(2'b01, 2'b01, 2'b01,  3,  0, 16'h0001, 16'h0000, 16'h0003, 16'h0000, 1'b0);
    tbl[14] = mk(2'b10, 2'b00, 2'b00,  0,  3, 16'h0000, 16'h0000, 16'h0000, 16'h0004, 1'b0);
    tbl[15] = mk(2'b11, 2'b10, 2'b10,  3,  3, 16'h0000, 16'h0001, 16'h0004, 16'h0004, 1'b0);
    tbl[16] = mk(2'b11, 2'b11, 2'b11,  3,  3, 16'h0002, 16'h0064, 16'h0005, 16'h0005, 1'b1);
    tbl[17] = mk(2'b01, 2'b00, 2'b00,  3,  0, 16'h0000, 16'h0000, 16'h0007, 16'h0000, 1'b0);
    tbl[18] = mk(2'b00, 2'b11, 2'b00,  3,  3, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 1'b0);
    tbl[19] = mk(2'b11, 2'b11, 2'b00, 20, 21, 16'h0101, 16'h0202, 16'h0000, 16'h0000, 1'b0);
    tbl[20] = mk(2'b11, 2'b00, 2'b00, 21, 20, 16'h0000, 16'h0000, 16'h0202, 16'h0101, 1'b0);
    tbl[21] = mk(2'b01, 2'b00, 2'b00,  3,  0, 16'h0000, 16'h0000, 16'h0007, 16'h0000, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", DATA_W'(busy), '0);
    check("rst_pkt_valid_out", DATA_W'(pkt_valid_out), '0);
    check("rst_addr_out", DATA_W'(addr_out), '0);
    check("rst_data_out0", data_out[DATA_W-1:0], '0);
    check("rst_data_out1", data_out[2*DATA_W-1:DATA_W], '0);
    check("rst_scan_out_valid", DATA_W'(scan_out_valid), '0);
    check("rst_scan_out_data", scan_out_data, '0);
    check("rst_collision_err", DATA_W'(collision_err), '0);
    reset = 1'b1;
    step();

    do_clear();
    scan_out_check(0);

    // Packets outside RUN must neither respond nor write.
    pkt_valid_in = 2'b11; pkt_we_in = 2'b11; pkt_acc_in = 2'b00;
    addr_in = {7'd5, 7'd5}; data_in = {rep(16'hFFFF), rep(16'hFFFF)};
    step();
    check("idle_pkt_ignored", DATA_W'(pkt_valid_out), '0);
    pkt_valid_in = '0;

    send_cmd(2'd0);
    for (int i = 0; i < NV; i++) begin
      pkt_cycle(tbl[i].v, tbl[i].we, tbl[i].acc, tbl[i].a0, tbl[i].a1,
                rep(tbl[i].l0), rep(tbl[i].l1));
      check_resp($sformatf("vec%0d", i), tbl[i].v, tbl[i].a0, tbl[i].a1,
                 rep(tbl[i].e0), rep(tbl[i].e1), tbl[i].col);
    end

    for (int t = 0; t < 400; t++) begin
      logic [1:0]    v, we, acc;
      logic [AW-1:0] a0, a1;
      v   = 2'($urandom);
      we  = 2'($urandom);
      acc = 2'($urandom);
      a0  = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, DEPTH - 1)) : AW'($urandom_range(0, 3));
      a1  = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, DEPTH - 1)) : AW'($urandom_range(0, 3));
      pkt_cycle(v, we, acc, a0, a1, rand_lanes(), rand_lanes());
      check_resp($sformatf("rnd%0d", t), v, a0, a1, exp_d0, exp_d1, exp_col);
    end

    scan_out_check(1);
    scan_in_load();
    scan_out_check(2);

    // Reset part-way through CLEAR: rows already cleared stay cleared, the rest keep data.
    send_cmd(2'd3);
    repeat (10) step();
    reset = 1'b0;
    #1;
    check("clear_rst_busy", DATA_W'(busy), '0);
    for (int i = 0; i < 10; i++) model[i] = '0;
    reset = 1'b1;
    step();
    scan_out_check(2);

    // Reset part-way through SCAN_OUT drops valid and busy at once.
    send_cmd(2'd2);
    scan_out_ready = 1'b1;
    repeat (6) step();
    check("scan_mid_valid", DATA_W'(scan_out_valid), DATA_W'(1));
    reset = 1'b0;
    #1;
    check("scan_rst_busy", DATA_W'(busy), '0);
    check("scan_rst_valid", DATA_W'(scan_out_valid), '0);
    check("scan_rst_data", scan_out_data, '0);
    scan_out_ready = 1'b0;
    reset = 1'b1;
    step();

    send_cmd(2'd0);
    pkt_cycle(2'b11, 2'b00, 2'b00, 7'd0, 7'd127, '0, '0);
    check_resp("post_rst_read", 2'b11, 7'd0, 7'd127, exp_d0, exp_d1, exp_col);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
